// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage.
//   - Default widths for data, opcode and register index.
//   - ALU_* opcode encodings shared with the integer ALU.
//   - Zero-register index and the occupancy-state type.
package alu_operand_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 8;
  localparam int DEF_REG_AW = 5;

  localparam logic [DEF_REG_AW-1:0] ZERO_REG = '0;

  localparam logic [DEF_OP_W-1:0] ALU_NOP       = 8'h00;
  localparam logic [DEF_OP_W-1:0] ALU_ADDW      = 8'h01;
  localparam logic [DEF_OP_W-1:0] ALU_SUBW      = 8'h02;
  localparam logic [DEF_OP_W-1:0] ALU_AND       = 8'h03;
  localparam logic [DEF_OP_W-1:0] ALU_OR        = 8'h04;
  localparam logic [DEF_OP_W-1:0] ALU_XOR       = 8'h05;
  localparam logic [DEF_OP_W-1:0] ALU_SLLW      = 8'h06;
  localparam logic [DEF_OP_W-1:0] ALU_SRLW      = 8'h07;
  localparam logic [DEF_OP_W-1:0] ALU_SRAW      = 8'h08;
  localparam logic [DEF_OP_W-1:0] ALU_SLT       = 8'h09;
  localparam logic [DEF_OP_W-1:0] ALU_SLTU      = 8'h0A;
  localparam logic [DEF_OP_W-1:0] ALU_LU12IW    = 8'h0B;
  localparam logic [DEF_OP_W-1:0] ALU_PCADDU12I = 8'h0C;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Combinational operand resolver for one source register.
// Ports:
//   i_rs                       source index
//   i_rf_data                  regfile read data
//   i_ex_we/i_ex_is_load/i_ex_rd/i_ex_data   EX-stage tuple (held instruction)
//   i_mem_we/i_mem_rd/i_mem_data             MEM-stage tuple
//   i_wb_we/i_wb_rd/i_wb_data                WB-stage tuple
//   o_data                     resolved operand
// Priority: r0, EX, MEM, WB, regfile.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_ex_we,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_rf_data;
    if (i_rs == '0)
      o_data = '0;
    // A load's ex_result is an address, not the loaded value.
    else if (i_ex_we && !i_ex_is_load && (i_ex_rd == i_rs))
      o_data = i_ex_data;
    else if (i_mem_we && (i_mem_rd == i_rs))
      o_data = i_mem_data;
    else if (i_wb_we && (i_wb_rd == i_rs))
      o_data = i_wb_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Dispatch-to-execute pipeline register in front of the integer ALU.
// Resolves rs1/rs2 through EX/MEM/WB bypass and regfile data, substitutes
// PC/immediate, stalls on load-use, holds under backpressure, drops on flush.
// Ports:
//   clk, rst_n (async, active-low), flush
//   in_* : dispatch handshake and instruction fields, in_ready back
//   ex_result, mem_fwd_*, wb_fwd_* : bypass sources
//   out_* : registered ALU inputs and EX bookkeeping, out_ready in
module alu_operand_stage #(
  parameter int DATA_W = alu_operand_stage_pkg::DEF_DATA_W,
  parameter int OP_W   = alu_operand_stage_pkg::DEF_OP_W,
  parameter int REG_AW = alu_operand_stage_pkg::DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_aluop,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic              in_use_pc,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_aluop,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              out_is_load,
  output logic [DATA_W-1:0] out_pc
);

  import alu_operand_stage_pkg::*;

  stage_state_e      r_state, w_state_nxt;
  logic [OP_W-1:0]   r_aluop;
  logic [DATA_W-1:0] r_reg1, r_reg2, r_pc;
  logic [REG_AW-1:0] r_rd;
  logic              r_we, r_is_load;

  logic [DATA_W-1:0] w_rs1_val, w_rs2_val;
  logic              w_full, w_ex_we, w_hz, w_accept;

  assign w_full  = (r_state == S_FULL);
  assign w_ex_we = w_full && r_we;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
    .i_rs(in_rs1), .i_rf_data(in_rs1_data),
    .i_ex_we(w_ex_we), .i_ex_is_load(r_is_load), .i_ex_rd(r_rd), .i_ex_data(ex_result),
    .i_mem_we(mem_fwd_we), .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .i_wb_we(wb_fwd_we), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
    .o_data(w_rs1_val)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
    .i_rs(in_rs2), .i_rf_data(in_rs2_data),
    .i_ex_we(w_ex_we), .i_ex_is_load(r_is_load), .i_ex_rd(r_rd), .i_ex_data(ex_result),
    .i_mem_we(mem_fwd_we), .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .i_wb_we(wb_fwd_we), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
    .o_data(w_rs2_val)
  );

  // Only sources actually read by the instruction can create a load-use stall.
  assign w_hz = in_valid && w_full && r_is_load && r_we && (r_rd != ZERO_REG) &&
                ((!in_use_pc  && (in_rs1 == r_rd)) ||
                 (!in_use_imm && (in_rs2 == r_rd)));

  assign in_ready = !flush && !w_hz && (!w_full || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = S_EMPTY;
    else if (w_accept)
      w_state_nxt = S_FULL;
    else if (out_ready && (w_hz || !in_valid))
      w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluop   <= '0;
      r_reg1    <= '0;
      r_reg2    <= '0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_is_load <= 1'b0;
      r_pc      <= '0;
    end else if (w_accept) begin
      r_aluop   <= in_aluop;
      r_reg1    <= in_use_pc  ? in_pc  : w_rs1_val;
      r_reg2    <= in_use_imm ? in_imm : w_rs2_val;
      r_rd      <= in_rd;
      r_we      <= in_we;
      r_is_load <= in_is_load;
      r_pc      <= in_pc;
    end
  end

  assign out_valid   = w_full;
  assign out_aluop   = r_aluop;
  assign out_reg1    = r_reg1;
  assign out_reg2    = r_reg2;
  assign out_rd      = r_rd;
  assign out_we      = r_we;
  assign out_is_load = r_is_load;
  assign out_pc      = r_pc;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [7:0]  in_aluop;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_imm, in_use_pc, in_we, in_is_load;
  logic [31:0] ex_result;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_aluop;
  logic [31:0] out_reg1, out_reg2, out_pc;
  logic [4:0]  out_rd;
  logic        out_we, out_is_load;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model of what the stage should be holding.
  logic        m_valid;
  logic [7:0]  m_aluop;
  logic [31:0] m_r1, m_r2, m_pc;
  logic [4:0]  m_rd;
  logic        m_we, m_load;

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_W(32), .OP_W(8), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_pc(in_pc),
    .in_rd(in_rd), .in_we(in_we), .in_is_load(in_is_load),
    .ex_result(ex_result),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_reg1(out_reg1), .out_reg2(out_reg2), .out_rd(out_rd), .out_we(out_we),
    .out_is_load(out_is_load), .out_pc(out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0)                                         return 32'h0;
    if (m_valid && m_we && !m_load && m_rd == rs)        return ex_result;
    if (mem_fwd_we && mem_fwd_rd == rs)                  return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_rd == rs)                    return wb_fwd_data;
    return rf;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_aluop = 0; m_r1 = 0; m_r2 = 0; m_pc = 0; m_rd = 0; m_we = 0; m_load = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid},   {31'b0, m_valid});
    chk({tag, ".aluop"}, {24'b0, out_aluop},   {24'b0, m_aluop});
    chk({tag, ".reg1"},  out_reg1,             m_r1);
    chk({tag, ".reg2"},  out_reg2,             m_r2);
    chk({tag, ".rd"},    {27'b0, out_rd},      {27'b0, m_rd});
    chk({tag, ".we"},    {31'b0, out_we},      {31'b0, m_we});
    chk({tag, ".load"},  {31'b0, out_is_load}, {31'b0, m_load});
    chk({tag, ".pc"},    out_pc,               m_pc);
  endtask

  // Called shortly after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    logic hz, rdy, use1, use2, n_valid;
    logic [31:0] n_r1, n_r2;
    #2;
    use1 = !in_use_pc;
    use2 = !in_use_imm;
    hz  = in_valid && m_valid && m_load && m_we && (m_rd != 0) &&
          ((use1 && in_rs1 == m_rd) || (use2 && in_rs2 == m_rd));
    rdy = !flush && !hz && (!m_valid || out_ready);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
    n_r1 = in_use_pc  ? in_pc  : resolve(in_rs1, in_rs1_data);
    n_r2 = in_use_imm ? in_imm : resolve(in_rs2, in_rs2_data);
    n_valid = m_valid;
    if (flush) n_valid = 0;
    else if (in_valid && rdy) n_valid = 1;
    else if (out_ready && (hz || !in_valid)) n_valid = 0;
    @(posedge clk);
    if (!flush && in_valid && rdy) begin
      m_aluop = in_aluop; m_r1 = n_r1; m_r2 = n_r2; m_rd = in_rd;
      m_we = in_we; m_load = in_is_load; m_pc = in_pc;
    end
    m_valid = n_valid;
    #1;
    chk_outputs(tag);
  endtask

  task automatic quiet_inputs();
    flush = 0; in_valid = 0; in_aluop = 0; in_rs1 = 0; in_rs2 = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0; in_use_pc = 0;
    in_pc = 0; in_rd = 0; in_we = 0; in_is_load = 0; ex_result = 0;
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0; out_ready = 1;
  endtask

  task automatic instr(input logic [7:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [4:0] rd, input logic ld);
    in_valid = 1; in_aluop = op; in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2;
    in_rs2_data = d2; in_rd = rd; in_we = 1; in_is_load = ld;
    in_use_imm = 0; in_use_pc = 0; in_pc = 32'h1C00_0100; in_imm = 0;
  endtask

  initial begin
    quiet_inputs();
    model_clear();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    rst_n = 1;

    // Basic
    instr(ALU_ADDW, 5'd3, 32'd5, 5'd4, 32'd7, 5'd8, 0);
    cycle("basic");
    chk("basic.reg1_const", out_reg1, 32'd5);
    chk("basic.reg2_const", out_reg2, 32'd7);

    // EX bypass beats MEM bypass
    instr(ALU_ADDW, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 0);
    cycle("exb_setup");
    instr(ALU_SUBW, 5'd3, 32'h99, 5'd0, 32'h55, 5'd9, 0);
    ex_result = 32'h10; mem_fwd_we = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h20;
    cycle("exb");
    chk("exb.reg1_const", out_reg1, 32'h10);
    chk("exb.reg2_zero", out_reg2, 32'h0);
    mem_fwd_we = 0; ex_result = 0;

    // Load-use: one bubble, then MEM bypass supplies the load data
    instr(ALU_ADDW, 5'd1, 32'd1, 5'd0, 32'd0, 5'd6, 1);
    cycle("lu_load");
    instr(ALU_ADDW, 5'd0, 32'd0, 5'd6, 32'h1111, 5'd7, 0);
    cycle("lu_stall");
    chk("lu_stall.valid_const", {31'b0, out_valid}, 32'd0);
    mem_fwd_we = 1; mem_fwd_rd = 5'd6; mem_fwd_data = 32'hABCD;
    cycle("lu_resume");
    chk("lu_resume.reg2_const", out_reg2, 32'hABCD);
    mem_fwd_we = 0;

    // Backpressure: 3 stalled cycles, then drain and accept
    instr(ALU_OR, 5'd2, 32'h22, 5'd5, 32'h55, 5'd10, 0);
    out_ready = 0;
    repeat (3) begin
      cycle("bp_hold");
      chk("bp_hold.in_ready_const", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1;
    cycle("bp_drain");

    // Immediate/PC: a pending load to rs1/rs2 causes no stall
    instr(ALU_ADDW, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 1);
    cycle("ip_load");
    instr(ALU_PCADDU12I, 5'd5, 32'h77, 5'd5, 32'h88, 5'd11, 0);
    in_use_pc = 1; in_pc = 32'h1C00_0000; in_use_imm = 1; in_imm = 32'h5000;
    cycle("ip");
    chk("ip.reg1_const", out_reg1, 32'h1C00_0000);
    chk("ip.reg2_const", out_reg2, 32'h5000);

    // Flush with full stage and incoming instruction
    instr(ALU_XOR, 5'd1, 32'h1, 5'd2, 32'h2, 5'd12, 0);
    flush = 1;
    cycle("flush");
    chk("flush.valid_const", {31'b0, out_valid}, 32'd0);
    flush = 0;

    // Flush while stalled under backpressure
    cycle("flush_refill");
    out_ready = 0;
    cycle("flush_bp_hold");
    flush = 1;
    cycle("flush_bp");
    flush = 0; out_ready = 1;

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_aluop     = 8'($urandom_range(0, 12));
      in_rs1       = 5'($urandom_range(0, 7));
      in_rs2       = 5'($urandom_range(0, 7));
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      in_pc        = $urandom;
      in_use_imm   = ($urandom_range(0, 3) == 0);
      in_use_pc    = ($urandom_range(0, 3) == 0);
      in_rd        = 5'($urandom_range(0, 7));
      in_we        = ($urandom_range(0, 4) != 0);
      in_is_load   = ($urandom_range(0, 2) == 0);
      ex_result    = $urandom;
      mem_fwd_we   = $urandom_range(0, 1);
      mem_fwd_rd   = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      wb_fwd_we    = $urandom_range(0, 1);
      wb_fwd_rd    = 5'($urandom_range(0, 7));
      wb_fwd_data  = $urandom;
      out_ready    = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 29) == 0);
      cycle("rand");
    end

    // Asynchronous reset mid-stream, then accept right after release
    quiet_inputs();
    instr(ALU_AND, 5'd1, 32'hF0, 5'd2, 32'h0F, 5'd13, 0);
    cycle("ar_fill");
    #2;
    rst_n = 0;
    #1;
    model_clear();
    chk_outputs("async_rst");
    chk("async_rst.valid_const", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    instr(ALU_ADDW, 5'd3, 32'h33, 5'd4, 32'h44, 5'd14, 0);
    cycle("post_rst");
    chk("post_rst.valid_const", {31'b0, out_valid}, 32'd1);
    chk("post_rst.reg1_const", out_reg1, 32'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
